// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into instruction words and
// streams the legal ones into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              mem_ready,
    output logic [15:0]       word_count,
    output logic              done,
    output logic              err_opcode,
    output logic              err_range
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    logic              r_wr_en;
    logic [31:0]       r_wr_data;
    logic [ADDR_W-1:0] r_ptr;
    logic [15:0]       r_count;
    logic              r_done;
    logic              r_err_opcode;
    logic              r_err_range;

    logic        w_is_r;
    logic        w_is_il;
    logic        w_is_s;
    logic        w_is_b;
    logic        w_opcode_ok;
    logic        w_imm12_ok;
    logic        w_imm13_ok;
    logic        w_range_ok;
    logic        w_accept;
    logic        w_legal;
    logic        w_complete;
    logic [31:0] w_word;

    assign w_is_r      = (opcode == OP_R);
    assign w_is_il     = (opcode == OP_I) || (opcode == OP_L);
    assign w_is_s      = (opcode == OP_S);
    assign w_is_b      = (opcode == OP_B);
    assign w_opcode_ok = w_is_r || w_is_il || w_is_s || w_is_b;

    // The immediate must survive truncation: all upper bits equal the field's sign bit.
    assign w_imm12_ok = (imm[31:11] == {21{imm[11]}});
    assign w_imm13_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign w_range_ok = w_is_b ? w_imm13_ok : ((w_is_il || w_is_s) ? w_imm12_ok : 1'b1);

    assign in_ready   = rst && !clear && !r_done && (!r_wr_en || mem_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_legal    = w_opcode_ok && w_range_ok;
    assign w_complete = r_wr_en && mem_ready;

    always_comb begin
        w_word = 32'd0;
        if (w_is_r) begin
            w_word = {funct7, rs2, rs1, funct3, rd, opcode};
        end else if (w_is_il) begin
            w_word = {imm[11:0], rs1, funct3, rd, opcode};
        end else if (w_is_s) begin
            w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        end else if (w_is_b) begin
            w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_en      <= 1'b0;
            r_wr_data    <= 32'd0;
            r_ptr        <= ADDR_W'(BASE_ADDR);
            r_count      <= 16'd0;
            r_done       <= 1'b0;
            r_err_opcode <= 1'b0;
            r_err_range  <= 1'b0;
        end else if (clear) begin
            r_wr_en      <= 1'b0;
            r_ptr        <= ADDR_W'(BASE_ADDR);
            r_count      <= 16'd0;
            r_done       <= 1'b0;
            r_err_opcode <= 1'b0;
            r_err_range  <= 1'b0;
        end else begin
            if (w_complete) begin
                r_ptr   <= r_ptr + ADDR_W'(4);
                r_count <= r_count + 16'd1;
                r_done  <= ((r_count + 16'd1) == 16'(DEPTH));
            end
            // A new legal word replaces the completing one without a bubble.
            if (w_accept && w_legal) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word;
            end else if (w_complete) begin
                r_wr_en <= 1'b0;
            end
            if (w_accept && !w_opcode_ok) begin
                r_err_opcode <= 1'b1;
            end
            if (w_accept && w_opcode_ok && !w_range_ok) begin
                r_err_range <= 1'b1;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_ptr;
    assign wr_data    = r_wr_data;
    assign word_count = r_count;
    assign done       = r_done;
    assign err_opcode = r_err_opcode;
    assign err_range  = r_err_range;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan steps plus randomized traffic,
// checked cycle by cycle against an arithmetic model of the encoder.
module tb_instr_encoder;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clear, in_valid, mem_ready;
    logic [6:0]    opcode, funct7;
    logic [4:0]    rd, rs1, rs2;
    logic [2:0]    funct3;
    logic [31:0]   imm;

    logic          a_in_ready, a_wr_en, a_done, a_err_opcode, a_err_range;
    logic [AW-1:0] a_wr_addr;
    logic [31:0]   a_wr_data;
    logic [15:0]   a_word_count;

    logic          b_in_ready, b_wr_en, b_done, b_err_opcode, b_err_range;
    logic [AW-1:0] b_wr_addr;
    logic [31:0]   b_wr_data;
    logic [15:0]   b_word_count;

    int total = 0;
    int bad   = 0;

    bit          mWrEn, mDone, mErrOp, mErrRange;
    logic [31:0] mData;
    int          mPtr, mCount;

    instr_encoder #(.ADDR_W(AW), .DEPTH(256), .BASE_ADDR(0)) u_dutA (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .mem_ready(mem_ready), .word_count(a_word_count), .done(a_done),
        .err_opcode(a_err_opcode), .err_range(a_err_range)
    );

    // Small-depth instance used to exercise the done/full behaviour.
    instr_encoder #(.ADDR_W(AW), .DEPTH(2), .BASE_ADDR(0)) u_dutB (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .mem_ready(mem_ready), .word_count(b_word_count), .done(b_done),
        .err_opcode(b_err_opcode), .err_range(b_err_range)
    );

    // kind: 0 legal, 1 unsupported opcode, 2 immediate out of range or misaligned.
    function automatic void encode(input int op, input int d, input int s1, input int s2,
                                   input int f3, input int f7, input int iv,
                                   output int kind, output logic [31:0] word);
        longint w;
        int     u;
        kind = 0;
        w    = 0;
        case (op)
            'h33: w = (longint'(f7) << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
            'h13, 'h03: begin
                if (iv < -2048 || iv > 2047) kind = 2;
                else begin
                    u = (iv + 4096) % 4096;
                    w = (longint'(u) << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
                end
            end
            'h23: begin
                if (iv < -2048 || iv > 2047) kind = 2;
                else begin
                    u = (iv + 4096) % 4096;
                    w = (longint'(u / 32) << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12)
                        + ((u % 32) << 7) + op;
                end
            end
            'h63: begin
                if (iv < -4096 || iv > 4094 || (iv % 2) != 0) kind = 2;
                else begin
                    u = (iv + 8192) % 8192;
                    w = (longint'(u / 4096) << 31) + (longint'((u / 32) % 64) << 25)
                        + (s2 << 20) + (s1 << 15) + (f3 << 12) + (((u / 2) % 16) << 8)
                        + (((u / 2048) % 2) << 7) + op;
                end
            end
            default: kind = 1;
        endcase
        word = w[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input int iv, input bit mr);
        in_valid  = v;
        opcode    = op;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        funct3    = f3;
        funct7    = f7;
        imm       = iv;
        mem_ready = mr;
    endtask

    task automatic idle(input bit mr);
        applyStimulus(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 0, mr);
    endtask

    // Compare instance A with the model, advance the model over one clock edge.
    task automatic step();
        bit          ready, acc, comp;
        int          kind;
        logic [31:0] word;
        #1;
        ready = rst && !clear && !mDone && (!mWrEn || mem_ready);
        checkOutput("in_ready",   a_in_ready,   ready);
        checkOutput("wr_en",      a_wr_en,      mWrEn);
        checkOutput("wr_addr",    a_wr_addr,    mPtr);
        checkOutput("wr_data",    a_wr_data,    mData);
        checkOutput("word_count", a_word_count, mCount);
        checkOutput("done",       a_done,       mDone);
        checkOutput("err_opcode", a_err_opcode, mErrOp);
        checkOutput("err_range",  a_err_range,  mErrRange);
        encode(opcode, rd, rs1, rs2, funct3, funct7, $signed(imm), kind, word);
        if (!rst) begin
            mWrEn = 0; mData = 0; mPtr = 0; mCount = 0; mDone = 0; mErrOp = 0; mErrRange = 0;
        end else if (clear) begin
            mWrEn = 0; mPtr = 0; mCount = 0; mDone = 0; mErrOp = 0; mErrRange = 0;
        end else begin
            acc  = in_valid && ready;
            comp = mWrEn && mem_ready;
            if (comp) begin
                mPtr   += 4;
                mCount += 1;
            end
            mDone = (mCount == 256);
            if (acc && kind == 0) begin
                mWrEn = 1;
                mData = word;
            end else if (comp) begin
                mWrEn = 0;
            end
            if (acc && kind == 1) mErrOp = 1;
            if (acc && kind == 2) mErrRange = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        idle(1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        logic [6:0] opList [8];
        int         immList [10];
        opList  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h00};
        immList = '{-4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095, 4096, 0};

        rst = 1'b0;
        clear = 1'b0;
        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        mWrEn = 0; mData = 0; mPtr = 0; mCount = 0; mDone = 0; mErrOp = 0; mErrRange = 0;
        step();
        checkOutput("rst_wr_addr", a_wr_addr, 32'd0);
        rst = 1'b1;

        $display("[TB] addi encoding");
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 1);
        step();
        checkOutput("addi_wr_en", a_wr_en, 32'd1);
        checkOutput("addi_addr", a_wr_addr, 32'd0);
        checkOutput("addi_data", a_wr_data, 32'h00500093);
        idle(1'b1);
        step();
        checkOutput("addi_count", a_word_count, 32'd1);

        $display("[TB] back-to-back R/S/B");
        pulseClear();
        applyStimulus(1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0, 1);
        step();
        checkOutput("add_data", a_wr_data, 32'h002081B3);
        checkOutput("add_addr", a_wr_addr, 32'd0);
        applyStimulus(1, 7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 8, 1);
        step();
        checkOutput("sw_data", a_wr_data, 32'h0020A423);
        checkOutput("sw_addr", a_wr_addr, 32'd4);
        applyStimulus(1, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -8, 1);
        step();
        checkOutput("beq_data", a_wr_data, 32'hFE208CE3);
        checkOutput("beq_addr", a_wr_addr, 32'd8);
        idle(1'b1);
        step();
        checkOutput("b2b_count", a_word_count, 32'd3);

        $display("[TB] backpressure");
        pulseClear();
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0, 0);
            #1;
            checkOutput("bp_in_ready", a_in_ready, 32'd0);
            step();
            checkOutput("bp_hold_data", a_wr_data, 32'h00500093);
            checkOutput("bp_hold_addr", a_wr_addr, 32'd0);
        end
        applyStimulus(1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 0, 1);
        step();
        checkOutput("bp_second_addr", a_wr_addr, 32'd4);
        checkOutput("bp_second_data", a_wr_data, 32'h002081B3);
        idle(1'b1);
        step();

        $display("[TB] illegal bundles");
        pulseClear();
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048, 1);
        step();
        checkOutput("ierr_wr_en", a_wr_en, 32'd0);
        checkOutput("ierr_range", a_err_range, 32'd1);
        applyStimulus(1, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3, 1);
        step();
        applyStimulus(1, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 1);
        step();
        checkOutput("op_err", a_err_opcode, 32'd1);
        checkOutput("op_err_range_kept", a_err_range, 32'd1);
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 5, 1);
        step();
        checkOutput("after_err_wr_en", a_wr_en, 32'd1);
        checkOutput("after_err_addr", a_wr_addr, 32'd0);
        idle(1'b1);
        step();

        $display("[TB] reset during pending write");
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 7, 0);
        step();
        idle(1'b0);
        rst = 1'b0;
        step();
        checkOutput("rstw_wr_en", a_wr_en, 32'd0);
        checkOutput("rstw_addr", a_wr_addr, 32'd0);
        checkOutput("rstw_count", a_word_count, 32'd0);
        rst = 1'b1;
        idle(1'b1);
        step();

        $display("[TB] full at depth 2");
        pulseClear();
        applyStimulus(1, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 0, 1);
        step();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, i, 1);
            step();
            idle(1'b1);
            step();
        end
        checkOutput("full_done", b_done, 32'd1);
        checkOutput("full_count", b_word_count, 32'd2);
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 9, 1);
        #1;
        checkOutput("full_in_ready", b_in_ready, 32'd0);
        step();
        checkOutput("full_no_write", b_wr_en, 32'd0);
        checkOutput("full_count_kept", b_word_count, 32'd2);
        pulseClear();
        checkOutput("clr_done", b_done, 32'd0);
        checkOutput("clr_count", b_word_count, 32'd0);
        checkOutput("clr_err_op", b_err_opcode, 32'd0);
        checkOutput("clr_err_range", b_err_range, 32'd0);
        applyStimulus(1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 3, 1);
        step();
        checkOutput("clr_next_wr_en", b_wr_en, 32'd1);
        checkOutput("clr_next_addr", b_wr_addr, 32'd0);
        idle(1'b1);
        step();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            int iv;
            case ($urandom_range(0, 3))
                0:       iv = immList[$urandom_range(0, 9)];
                1:       iv = int'($urandom);
                2:       iv = int'($urandom_range(0, 8191)) - 4096;
                default: iv = int'($urandom_range(0, 4095)) - 2048;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, opList[$urandom_range(0, 7)],
                          5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                          7'($urandom), iv, $urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 96) != 0);
            step();
        end
        clear = 1'b0;
        rst   = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- RV32I instruction encoder; the inverse of the decode-stage immediate extractor.
- Accepts decoded fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word, range-checks the immediate, and writes legal words sequentially into instruction memory.
- Used by the test-program loader and self-check benches to build programs in instruction memory.

Parameters:
- ADDR_W, 10, width of the instruction-memory byte address.
- DEPTH, 256, maximum number of words written before done; DEPTH*4 + BASE_ADDR <= 2**ADDR_W.
- BASE_ADDR, 0, byte address of the first written word; multiple of 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- clear  in  1  synchronous restart of address and status; no data path effect beyond that.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- opcode  in  7  supported: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011.
- rd  in  5  destination register (R/I/L).
- rs1  in  5  source register 1 (R/I/L/S/B).
- rs2  in  5  source register 2 (R/S/B).
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- imm  in  32  signed immediate; for B this is the byte offset.
- wr_en  out  1  write request to instruction memory.
- wr_addr  out  ADDR_W  byte address of the current write.
- wr_data  out  32  encoded instruction word.
- mem_ready  in  1  memory accepts the write when wr_en && mem_ready.
- word_count  out  16  number of completed writes.
- done  out  1  word_count == DEPTH.
- err_opcode  out  1  sticky: an unsupported opcode was received.
- err_range  out  1  sticky: an immediate was out of range or misaligned.

Behaviour:
- Reset (rst == 0 at the edge): wr_en=0, wr_data=0, wr_addr=BASE_ADDR, word_count=0, done=0, err_opcode=0, err_range=0. in_ready is 0 while rst == 0.
- Handshake:
  - in_ready = rst && !clear && !done && (!wr_en || mem_ready).
  - A transfer occurs when in_valid && in_ready.
- Encoding is standard RV32I:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I/L: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Fields not used by a format are ignored.
- Range rules:
  - I/L/S: imm must equal the sign-extension of imm[11:0], i.e. -2048..2047.
  - B: imm must equal the sign-extension of imm[12:0], and imm[0] must be 0, i.e. -4096..4094.
  - R: imm ignored.
- Pipeline (one register stage):
  - A legal bundle accepted in cycle N gives wr_en=1 and wr_data=encoded word in cycle N+1.
  - wr_addr is the current pointer.
  - wr_en, wr_data and wr_addr are held stable while mem_ready == 0.
- Write completion (wr_en && mem_ready at the edge):
  - pointer += 4 and word_count += 1.
  - wr_en drops unless a new legal bundle is accepted the same cycle. In that case the new word appears next cycle at the incremented address, with no bubble.
- Illegal bundles:
  - An illegal bundle is still consumed (handshake completes).
  - No write occurs; pointer and word_count are unchanged.
  - The matching sticky flag is set one cycle later.
  - An unsupported opcode sets only err_opcode; the range check is not applied.
- Full: when word_count reaches DEPTH, done=1 in the same cycle word_count updates. in_ready stays 0 until clear or reset.
- clear:
  - Priority below rst and above everything else.
  - Drops any pending word (wr_en=0), sets pointer to BASE_ADDR, word_count=0, done=0, and clears both error flags.
  - A bundle presented in the clear cycle is not accepted.
  - A write pending with mem_ready in the clear cycle does not count.
- Reset mid-write: the pending word is discarded and no retry is made.
- Widths: the pointer does not wrap, because done stops input at DEPTH.

Test Plan:
- Reset, then opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, mem_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00500093; word_count=1 after the write.
- Back-to-back R, S, B bundles with mem_ready=1:
  - add x3,x1,x2 -> 0x002081B3 @0.
  - sw x2,8(x1) (funct3=010, imm=8) -> 0x0020A423 @4.
  - beq x1,x2,imm=-8 -> 0xFE208CE3 @8.
  - No bubbles; word_count=3.
- Backpressure: first word written while mem_ready=0 for 3 cycles -> wr_en, wr_addr, wr_data held and in_ready=0; in the cycle mem_ready=1 a second bundle is accepted; the second word appears at address 4 the following cycle.
- Errors:
  - I imm=2048 -> no wr_en, err_range=1, pointer unchanged.
  - B imm=3 -> err_range stays 1.
  - opcode 0110111 -> err_opcode=1.
  - A following legal bundle is still written at address 0.
- DEPTH=2: two legal writes -> done=1, in_ready=0, and a third in_valid is not accepted. Then clear -> done=0, word_count=0, errors=0, and the next write goes to BASE_ADDR.
- Reset asserted while wr_en=1 and mem_ready=0 -> next cycle wr_en=0, wr_addr=BASE_ADDR, word_count=0.
